// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator.
// Defaults describe 640x480@60 at a 25.175 MHz pixel clock.
package video_timing_pkg;

  localparam int TIMING_CNT_W = 12;
  localparam int TIMING_MAX_TOTAL = 1 << TIMING_CNT_W;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // One axis is legal when every phase is non-empty and the line/frame fits the counter.
  function automatic bit timing_legal(input int act, input int fp, input int sync, input int bp);
    return (act >= 1) && (fp >= 1) && (sync >= 1) && (bp >= 1) &&
           ((act + fp + sync + bp) <= TIMING_MAX_TOTAL);
  endfunction

  function automatic phase_t phase_next(input phase_t p);
    phase_t n;
    case (p)
      PH_ACTIVE: n = PH_FRONT;
      PH_FRONT:  n = PH_SYNC;
      PH_SYNC:   n = PH_BACK;
      default:   n = PH_ACTIVE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Sync/coordinate bundle from the timing generator to encoders and pattern generators.
interface video_timing_if;
  import video_timing_pkg::*;

  logic                    blank;
  logic                    hsync;
  logic                    vsync;
  logic [TIMING_CNT_W-1:0] x;
  logic [TIMING_CNT_W-1:0] y;
  logic                    line_start;
  logic                    frame_start;

  modport master (
    output blank, hsync, vsync, x, y, line_start, frame_start
  );

  modport slave (
    input blank, hsync, vsync, x, y, line_start, frame_start
  );

endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: position counter plus a 4-phase FSM with an in-phase down-counter.
// cnt/phase/wrap describe the position the axis moves to on the next edge.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    adv,
  output logic [TIMING_CNT_W-1:0] cnt,
  output phase_t                  phase,
  output logic                    wrap
);

  typedef logic [TIMING_CNT_W-1:0] cnt_t;

  localparam int   TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam cnt_t CNT_LAST = cnt_t'(TOTAL - 1);
  localparam cnt_t ONE      = cnt_t'(1);

  // Cycles left in a phase, minus one, on entry to that phase.
  function automatic cnt_t phase_last(input phase_t p);
    cnt_t r;
    case (p)
      PH_ACTIVE: r = cnt_t'(ACTIVE - 1);
      PH_FRONT:  r = cnt_t'(FP - 1);
      PH_SYNC:   r = cnt_t'(SYNC - 1);
      default:   r = cnt_t'(BP - 1);
    endcase
    return r;
  endfunction

  cnt_t   cnt_q, cnt_d;
  cnt_t   rem_q, rem_d;
  phase_t phase_q, phase_d;
  logic   wrap_d;

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    wrap_d  = adv && (phase_q == PH_BACK) && (rem_q == '0);
    if (adv) begin
      if (rem_q == '0) begin
        phase_d = phase_next(phase_q);
        rem_d   = phase_last(phase_d);
      end else begin
        rem_d = rem_q - ONE;
      end
      cnt_d = wrap_d ? '0 : cnt_q + ONE;
    end
  end

  // Parked at the last count of BACK so the first advance after reset lands on 0/ACTIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= CNT_LAST;
      rem_q   <= '0;
      phase_q <= PH_BACK;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
    end
  end

  assign cnt   = cnt_d;
  assign phase = phase_d;
  assign wrap  = wrap_d;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: two chained axes, outputs decoded from their next state
// and registered together so sync, blank, strobes and coordinates share one cycle.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  video_timing_if.master vif
);

  typedef logic [TIMING_CNT_W-1:0] cnt_t;

  if (!timing_legal(H_ACTIVE, H_FP, H_SYNC, H_BP)) begin : g_bad_h
    $error("video_timing: illegal horizontal geometry %0d/%0d/%0d/%0d",
           H_ACTIVE, H_FP, H_SYNC, H_BP);
  end
  if (!timing_legal(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_bad_v
    $error("video_timing: illegal vertical geometry %0d/%0d/%0d/%0d",
           V_ACTIVE, V_FP, V_SYNC, V_BP);
  end

  cnt_t   h_cnt, v_cnt;
  phase_t h_phase, v_phase;
  logic   h_wrap, v_wrap;

  video_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .adv   (1'b1),
    .cnt   (h_cnt),
    .phase (h_phase),
    .wrap  (h_wrap)
  );

  // The vertical axis steps on the same edge the horizontal one wraps.
  video_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .adv   (h_wrap),
    .cnt   (v_cnt),
    .phase (v_phase),
    .wrap  (v_wrap)
  );

  logic blank_q, blank_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    blank_d       = !((h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE));
    hsync_d       = (h_phase == PH_SYNC) ? H_SYNC_POL : !H_SYNC_POL;
    vsync_d       = (v_phase == PH_SYNC) ? V_SYNC_POL : !V_SYNC_POL;
    x_d           = h_cnt;
    y_d           = v_cnt;
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q       <= 1'b1;
      hsync_q       <= !H_SYNC_POL;
      vsync_q       <= !V_SYNC_POL;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vif.blank       = blank_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Three generators (tiny, small with positive syncs, default 640x480) checked each cycle
// against a region-based raster model through a scoreboard queue.
module tb_video_timing;
  import video_timing_pkg::*;

  typedef struct packed {
    logic        blank;
    logic        hsync;
    logic        vsync;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
  } exp_t;

  localparam int ND = 3;

  int ha[ND] = '{4, 8, 640};
  int hf[ND] = '{1, 2, 16};
  int hs[ND] = '{1, 3, 96};
  int hb[ND] = '{1, 2, 48};
  int va[ND] = '{2, 4, 480};
  int vf[ND] = '{1, 1, 10};
  int vs[ND] = '{1, 2, 2};
  int vb[ND] = '{1, 2, 33};
  bit hp[ND] = '{1'b0, 1'b1, 1'b0};
  bit vp[ND] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_timing_if vif_a ();
  video_timing_if vif_b ();
  video_timing_if vif_c ();

  video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut_a (.clk(clk), .reset(reset), .vif(vif_a));

  video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_b (.clk(clk), .reset(reset), .vif(vif_b));

  video_timing dut_c (.clk(clk), .reset(reset), .vif(vif_c));

  exp_t  sb[$];
  int    mx[ND], my[ND];
  bit    parked[ND];
  int    last_ls[ND], last_fs[ND];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  string tag = "init";

  function automatic exp_t observe(input int d);
    exp_t o;
    case (d)
      0: o = '{vif_a.blank, vif_a.hsync, vif_a.vsync, vif_a.x, vif_a.y, vif_a.line_start, vif_a.frame_start};
      1: o = '{vif_b.blank, vif_b.hsync, vif_b.vsync, vif_b.x, vif_b.y, vif_b.line_start, vif_b.frame_start};
      default: o = '{vif_c.blank, vif_c.hsync, vif_c.vsync, vif_c.x, vif_c.y, vif_c.line_start, vif_c.frame_start};
    endcase
    return o;
  endfunction

  // Model: advance the raster position, then classify it by region bounds.
  task automatic push_expected(input int d, input bit rst);
    exp_t e;
    int htot, vtot;
    bit in_hs, in_vs;
    htot = ha[d] + hf[d] + hs[d] + hb[d];
    vtot = va[d] + vf[d] + vs[d] + vb[d];
    if (rst) begin
      parked[d] = 1'b1;
      e = '{1'b1, !hp[d], !vp[d], 12'd0, 12'd0, 1'b0, 1'b0};
    end else begin
      if (parked[d]) begin
        parked[d] = 1'b0;
        mx[d] = 0;
        my[d] = 0;
      end else begin
        mx[d]++;
        if (mx[d] == htot) begin
          mx[d] = 0;
          my[d]++;
          if (my[d] == vtot) my[d] = 0;
        end
      end
      in_hs = (mx[d] >= ha[d] + hf[d]) && (mx[d] < ha[d] + hf[d] + hs[d]);
      in_vs = (my[d] >= va[d] + vf[d]) && (my[d] < va[d] + vf[d] + vs[d]);
      e.blank = !((mx[d] < ha[d]) && (my[d] < va[d]));
      e.hsync = in_hs ? hp[d] : !hp[d];
      e.vsync = in_vs ? vp[d] : !vp[d];
      e.x     = 12'(mx[d]);
      e.y     = 12'(my[d]);
      e.ls    = (mx[d] == 0);
      e.fs    = (mx[d] == 0) && (my[d] == 0);
    end
    sb.push_back(e);
  endtask

  task automatic step(input bit rst);
    exp_t e, o;
    reset = rst;
    for (int d = 0; d < ND; d++) push_expected(d, rst);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      e = sb.pop_front();
      o = observe(d);
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s dut%0d cyc%0d: observed b%0b h%0b v%0b x%0d y%0d ls%0b fs%0b, expected b%0b h%0b v%0b x%0d y%0d ls%0b fs%0b",
               tag, d, cyc, o.blank, o.hsync, o.vsync, o.x, o.y, o.ls, o.fs,
               e.blank, e.hsync, e.vsync, e.x, e.y, e.ls, e.fs);
      end
      if (rst) begin
        last_ls[d] = -1;
        last_fs[d] = -1;
      end
      // Strobe periods measured straight from the DUT strobes, outside reset.
      if (o.ls === 1'b1 && !rst) begin
        if (last_ls[d] >= 0) begin
          vectors++;
          assert (cyc - last_ls[d] == ha[d] + hf[d] + hs[d] + hb[d]) else begin
            miscompares++;
            $error("FAIL %s dut%0d line period: observed %0d expected %0d", tag, d,
                   cyc - last_ls[d], ha[d] + hf[d] + hs[d] + hb[d]);
          end
        end
        last_ls[d] = cyc;
      end
      if (o.fs === 1'b1 && !rst) begin
        if (last_fs[d] >= 0) begin
          vectors++;
          assert (cyc - last_fs[d] == (ha[d] + hf[d] + hs[d] + hb[d]) * (va[d] + vf[d] + vs[d] + vb[d])) else begin
            miscompares++;
            $error("FAIL %s dut%0d frame period: observed %0d", tag, d, cyc - last_fs[d]);
          end
        end
        last_fs[d] = cyc;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      parked[d]  = 1'b1;
      last_ls[d] = -1;
      last_fs[d] = -1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    tag = "reset_hold";
    repeat (5) step(1'b1);

    tag = "release";
    step(1'b0);

    tag = "run";
    repeat (1700) step(1'b0);

    tag = "mid_reset";
    step(1'b1);
    tag = "restart";
    step(1'b0);
    repeat (250) step(1'b0);

    tag = "reset_pair";
    repeat (2) step(1'b1);
    tag = "run2";
    repeat (900) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
